// File: rtl/adam_mem_arb.sv
// adam_mem_arb: round-robin arbiter multiplexing requesters onto one memory port, with pause/drain handshake
module adam_mem_arb #(
  parameter int NO_REQS = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   pause_req,
  output logic                                   pause_ack,
  input  logic [NO_REQS-1:0]                     req_req,
  output logic [NO_REQS-1:0]                     req_gnt,
  input  logic [NO_REQS-1:0][ADDR_WIDTH-1:0]     req_addr,
  input  logic [NO_REQS-1:0]                     req_we,
  input  logic [NO_REQS-1:0][STRB_WIDTH-1:0]     req_be,
  input  logic [NO_REQS-1:0][DATA_WIDTH-1:0]     req_wdata,
  output logic [NO_REQS-1:0]                     req_rvalid,
  output logic [DATA_WIDTH-1:0]                  req_rdata,
  output logic                                   mem_req,
  output logic [ADDR_WIDTH-1:0]                  mem_addr,
  output logic                                   mem_we,
  output logic [STRB_WIDTH-1:0]                  mem_be,
  output logic [DATA_WIDTH-1:0]                  mem_wdata,
  input  logic [DATA_WIDTH-1:0]                  mem_rdata
);
  localparam int IW = NO_REQS > 1 ? $clog2(NO_REQS) : 1;
  typedef enum logic [1:0] {RUN, DRAIN, PAUSED} state_t;
  state_t state, next_state;
  logic [IW-1:0] last_gnt, gnt_idx;
  logic outstanding, gnt_en, found;
  int idx;
  // state register; pause_ack registered so it is high exactly while PAUSED
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pause_ack <= 1'b0;
    end else begin
      state <= next_state;
      pause_ack <= (next_state == PAUSED);
    end
  end
  // next state: drain until no response is in flight, then park until pause_req drops
  always_comb begin
    next_state = state;
    if (state == RUN) next_state = pause_req ? DRAIN : RUN;
    else if (state == DRAIN) next_state = !pause_req ? RUN : (outstanding ? DRAIN : PAUSED);
    else next_state = pause_req ? PAUSED : RUN;
  end
  // grants only while running, not pausing, and out of reset
  always_comb gnt_en = rst_n && (state == RUN) && !pause_req;
  // round-robin search starting just after the last winner
  always_comb begin
    req_gnt = '0;
    gnt_idx = last_gnt;
    found = 1'b0;
    idx = 0;
    for (int k = 1; k <= NO_REQS; k++) begin
      idx = (int'(last_gnt) + k) % NO_REQS;
      if (gnt_en && !found && req_req[idx]) begin
        found = 1'b1;
        req_gnt[idx] = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end
  // memory port driven by the granted requester, zero otherwise
  always_comb begin
    mem_addr = '0;
    mem_we = 1'b0;
    mem_be = '0;
    mem_wdata = '0;
    for (int i = 0; i < NO_REQS; i++) begin
      if (req_gnt[i]) begin
        mem_addr = req_addr[i];
        mem_we = req_we[i];
        mem_be = req_be[i];
        mem_wdata = req_wdata[i];
      end
    end
  end
  assign mem_req = |req_gnt;
  assign req_rdata = mem_rdata;
  // arbitration history and one-cycle-delayed response strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= IW'(NO_REQS - 1);
      req_rvalid <= '0;
      outstanding <= 1'b0;
    end else begin
      if (found) last_gnt <= gnt_idx;
      req_rvalid <= req_gnt;
      outstanding <= |req_gnt;
    end
  end
endmodule

// File: tb/tb_adam_mem_arb.sv
// tb_adam_mem_arb: directed scoreboard bench for adam_mem_arb (2- and 4-requester instances)
module tb_adam_mem_arb;
  logic clk = 1'b0, rst_n = 1'b0, pause_req = 1'b0;
  logic [1:0] req_req = '0, req_we = '0, req_gnt, req_rvalid;
  logic [1:0][31:0] req_addr = '0, req_wdata = '0;
  logic [1:0][3:0] req_be = '0;
  logic [31:0] req_rdata, mem_rdata, mem_addr, mem_wdata;
  logic mem_req, mem_we, pause_ack;
  logic [3:0] mem_be;
  logic [3:0] r4 = '0, we4 = '0, g4, v4;
  logic [3:0][31:0] a4 = '0, wd4 = '0;
  logic [3:0][3:0] be4 = '0;
  logic [31:0] rd4, m4_addr, m4_wdata;
  logic p4_ack, m4_req, m4_we;
  logic [3:0] m4_be;
  logic [31:0] mem [64];
  int cyc = 0, errors = 0, checks = 0;
  typedef struct {int cyc; logic [1:0] v; logic [31:0] d; bit care;} exp_t;
  exp_t q[$];
  exp_t e;

  adam_mem_arb #(.NO_REQS(2)) dut (
    .clk(clk), .rst_n(rst_n), .pause_req(pause_req), .pause_ack(pause_ack),
    .req_req(req_req), .req_gnt(req_gnt), .req_addr(req_addr), .req_we(req_we),
    .req_be(req_be), .req_wdata(req_wdata), .req_rvalid(req_rvalid), .req_rdata(req_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  adam_mem_arb #(.NO_REQS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .pause_req(1'b0), .pause_ack(p4_ack),
    .req_req(r4), .req_gnt(g4), .req_addr(a4), .req_we(we4),
    .req_be(be4), .req_wdata(wd4), .req_rvalid(v4), .req_rdata(rd4),
    .mem_req(m4_req), .mem_addr(m4_addr), .mem_we(m4_we), .mem_be(m4_be),
    .mem_wdata(m4_wdata), .mem_rdata(32'h0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model: byte-masked writes, registered read of the pre-write word
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[4] <= 32'hDEADBEEF;
      mem[8] <= 32'hAABBCCDD;
      mem_rdata <= '0;
    end else if (mem_req) begin
      for (int b = 0; b < 4; b++)
        if (mem_we && mem_be[b]) mem[mem_addr[7:2]][8*b+:8] <= mem_wdata[8*b+:8];
      mem_rdata <= mem[mem_addr[7:2]];
    end
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask

  task automatic expect_rsp(input logic [1:0] v, input logic [31:0] d, input bit care);
    q.push_back('{cyc + 1, v, d, care});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // response monitor
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("rvalid", 64'(req_rvalid), 64'(e.v));
      if (e.care) chk("rdata", 64'(req_rdata), 64'(e.d));
    end else if (req_rvalid !== 2'b00) chk("spurious_rvalid", 64'(req_rvalid), 64'd0);
  end

  initial begin
    logic [1:0] seq [4];
    seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    req_req = 2'b11;
    @(negedge clk);
    chk("rst_gnt", 64'(req_gnt), 0);
    chk("rst_mem_req", 64'(mem_req), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    chk("rst_ack", 64'(pause_ack), 0);
    chk("rst_rvalid", 64'(req_rvalid), 0);
    step();
    rst_n = 1'b1;
    req_addr[0] = 32'h30;
    req_addr[1] = 32'h34;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_gnt", 64'(req_gnt), 64'(seq[i]));
      expect_rsp(seq[i], 0, 0);
      step();
    end
    req_req = 2'b00;
    @(negedge clk);
    chk("idle_gnt", 64'(req_gnt), 0);
    step();
    req_req = 2'b10;
    req_addr[1] = 32'h10;
    @(negedge clk);
    chk("rd_gnt", 64'(req_gnt), 64'b10);
    chk("rd_mem_req", 64'(mem_req), 1);
    chk("rd_mem_we", 64'(mem_we), 0);
    chk("rd_mem_addr", 64'(mem_addr), 64'h10);
    expect_rsp(2'b10, 32'hDEADBEEF, 1);
    step();
    req_req = 2'b01;
    req_addr[0] = 32'h20;
    req_we[0] = 1'b1;
    req_be[0] = 4'b0011;
    req_wdata[0] = 32'h12345678;
    @(negedge clk);
    chk("wr_gnt", 64'(req_gnt), 64'b01);
    chk("wr_mem_we", 64'(mem_we), 1);
    chk("wr_mem_be", 64'(mem_be), 64'b0011);
    chk("wr_mem_wdata", 64'(mem_wdata), 64'h12345678);
    chk("wr_mem_addr", 64'(mem_addr), 64'h20);
    expect_rsp(2'b01, 0, 0);
    step();
    req_we[0] = 1'b0;
    @(negedge clk);
    chk("rb_gnt", 64'(req_gnt), 64'b01);
    expect_rsp(2'b01, 32'hAABB5678, 1);
    step();
    req_req = 2'b00;
    step();
    req_req = 2'b11;
    req_addr[0] = 32'h30;
    req_addr[1] = 32'h34;
    @(negedge clk);
    chk("pz_gnt1", 64'(req_gnt), 64'b10);
    expect_rsp(2'b10, 0, 0);
    step();
    @(negedge clk);
    chk("pz_gnt2", 64'(req_gnt), 64'b01);
    expect_rsp(2'b01, 0, 0);
    step();
    pause_req = 1'b1;
    @(negedge clk);
    chk("pz_req_gnt", 64'(req_gnt), 0);
    chk("pz_req_ack", 64'(pause_ack), 0);
    step();
    @(negedge clk);
    chk("drain_gnt", 64'(req_gnt), 0);
    chk("drain_ack", 64'(pause_ack), 0);
    step();
    @(negedge clk);
    chk("paused_ack", 64'(pause_ack), 1);
    chk("paused_gnt", 64'(req_gnt), 0);
    step();
    pause_req = 1'b0;
    @(negedge clk);
    chk("unpause_ack", 64'(pause_ack), 1);
    chk("unpause_gnt", 64'(req_gnt), 0);
    step();
    @(negedge clk);
    chk("resume_ack", 64'(pause_ack), 0);
    chk("resume_gnt", 64'(req_gnt), 64'b10);
    expect_rsp(2'b10, 0, 0);
    step();
    @(negedge clk);
    chk("resume_gnt2", 64'(req_gnt), 64'b01);
    expect_rsp(2'b01, 0, 0);
    step();
    pause_req = 1'b1;
    @(negedge clk);
    chk("abort_gnt", 64'(req_gnt), 0);
    step();
    pause_req = 1'b0;
    @(negedge clk);
    chk("abort_drain_gnt", 64'(req_gnt), 0);
    chk("abort_drain_ack", 64'(pause_ack), 0);
    step();
    @(negedge clk);
    chk("abort_run_gnt", 64'(req_gnt), 64'b10);
    chk("abort_run_ack", 64'(pause_ack), 0);
    expect_rsp(2'b10, 0, 0);
    step();
    req_req = 2'b00;
    step();
    req_req = 2'b01;
    req_addr[0] = 32'h10;
    @(negedge clk);
    chk("mid_gnt", 64'(req_gnt), 64'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 64'(req_gnt), 0);
    chk("mid_rst_mem_req", 64'(mem_req), 0);
    step();
    @(negedge clk);
    chk("mid_rst_rvalid", 64'(req_rvalid), 0);
    step();
    rst_n = 1'b1;
    req_req = 2'b11;
    @(negedge clk);
    chk("post_rst_gnt", 64'(req_gnt), 64'b01);
    expect_rsp(2'b01, 32'hDEADBEEF, 1);
    step();
    req_req = 2'b00;
    step();
    r4 = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("n4_gnt", 64'(g4), 64'b1000);
      if (i > 0) chk("n4_rvalid", 64'(v4), 64'b1000);
      step();
    end
    r4 = 4'b0000;
    @(negedge clk);
    chk("n4_last_rvalid", 64'(v4), 64'b1000);
    chk("n4_idle_gnt", 64'(g4), 0);
    step();
    @(negedge clk);
    chk("n4_rvalid_off", 64'(v4), 0);
    step();
    step();
    chk("queue_empty", 64'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
